// File: rtl/disp_pkg.sv
// Shared encodings for the disparity-to-colour display path: mapping modes,
// scheduler states and the frame pixel-count helper.
package disp_pkg;

  localparam logic [1:0] MODE_PSEUDO = 2'd0;
  localparam logic [1:0] MODE_GREY   = 2'd1;
  localparam logic [1:0] MODE_BLACK  = 2'd2;
  localparam logic [1:0] MODE_INV    = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int unsigned pix_count(input int unsigned h_act,
                                            input int unsigned v_act);
    return h_act * v_act;
  endfunction

endpackage

// File: rtl/hue_to_rgb.sv
// Combinational pseudo-colour ramp: red follows h, blue is its complement,
// green rises then falls across the range as a triangle.
module hue_to_rgb (
  input  logic [7:0] h,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  assign r = h;
  assign g = h[7] ? ~{h[6:0], 1'b0} : {h[6:0], 1'b0};
  assign b = ~h;

endmodule

// File: rtl/disp_color_sched.sv
// Frame scheduler for the shared disparity colour datapath: round-robin frame
// grant, gain with saturation, colour map, and a framed valid/ready output.
module disp_color_sched
  import disp_pkg::*;
#(
  parameter int unsigned H_ACT = 640,
  parameter int unsigned V_ACT = 480,
  parameter int unsigned CNT_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic       frame_start,
  input  logic [1:0] cfg_mode,
  input  logic [2:0] cfg_shift,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  output logic       s1_ready,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_r,
  output logic [7:0] m_g,
  output logic [7:0] m_b,
  output logic       m_sof,
  output logic       m_eol,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PIX    = pix_count(H_ACT, V_ACT);
  localparam int unsigned PIX_W  = $clog2(PIX + 1);
  localparam logic [PIX_W-1:0] PIX_ALL  = PIX_W'(PIX);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX - 1);
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_ACT - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_ACT - 1);

  function automatic logic [DATA_W-1:0] sat_shl(input logic [DATA_W-1:0] d,
                                                input logic [2:0]        s);
    logic [DATA_W+6:0] w;
    w = {7'd0, d} << s;
    return (|w[DATA_W+6:DATA_W]) ? {DATA_W{1'b1}} : w[DATA_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic               last_q;
  logic [1:0]         mode_q;
  logic [2:0]         shift_q;
  logic [PIX_W-1:0]   in_cnt_q;
  logic [CNT_W-1:0]   x_q, y_q;

  logic               adv, adv1, rdy, sel, in_vld, acc;
  logic               out_hs, out_last, start_ok, win;
  logic [DATA_W-1:0]  in_data;

  logic               vld_p1;
  logic [DATA_W-1:0]  h_p1;

  logic [DATA_W-1:0]  hue_in, hue_r, hue_g, hue_b;
  logic [DATA_W-1:0]  map_r, map_g, map_b;

  assign sel     = gnt[1];
  assign in_vld  = sel ? s1_valid : s0_valid;
  assign in_data = sel ? s1_data  : s0_data;

  // A stage may load when the stage after it is empty or draining this cycle.
  assign adv      = m_ready | ~m_valid;
  assign adv1     = adv | ~vld_p1;
  assign rdy      = (state_q == RUN) && (in_cnt_q < PIX_ALL) && adv1;
  assign s0_ready = rdy & gnt[0];
  assign s1_ready = rdy & gnt[1];
  assign acc      = rdy & in_vld;

  assign out_hs   = m_valid & m_ready;
  assign out_last = out_hs && (x_q == X_LAST) && (y_q == Y_LAST);
  assign win      = req[~last_q] ? ~last_q : last_q;

  assign m_sof = m_valid && (x_q == '0) && (y_q == '0);
  assign m_eol = m_valid && (x_q == X_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start && (req != 2'b00)) begin
          state_d  = RUN;
          start_ok = 1'b1;
        end
      end
      RUN:     if (acc && (in_cnt_q == PIX_LAST)) state_d = DRAIN;
      DRAIN:   if (out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= 2'b00;
      last_q     <= 1'b1;
      mode_q     <= MODE_PSEUDO;
      shift_q    <= 3'd0;
      in_cnt_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= (state_q == DRAIN) && out_last;
      frame_err  <= frame_start && (state_q != IDLE);
      if (start_ok) begin
        gnt      <= win ? 2'b10 : 2'b01;
        mode_q   <= cfg_mode;
        shift_q  <= cfg_shift;
        in_cnt_q <= '0;
      end
      if (acc) in_cnt_q <= in_cnt_q + PIX_W'(1);
      if (out_hs) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + CNT_W'(1);
        end else begin
          x_q <= x_q + CNT_W'(1);
        end
      end
      if ((state_q == DRAIN) && out_last) begin
        gnt      <= 2'b00;
        last_q   <= gnt[1];
        in_cnt_q <= '0;
        x_q      <= '0;
        y_q      <= '0;
      end
    end
  end

  // Stage 1: gain
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       vld_p1 <= 1'b0;
    else if (adv1) vld_p1 <= acc;
  end

  always_ff @(posedge clk) begin
    if (adv1 && acc) h_p1 <= sat_shl(in_data, shift_q);
  end

  // Stage 2: colour map
  assign hue_in = (mode_q == MODE_INV) ? ~h_p1 : h_p1;

  hue_to_rgb u_hue (
    .h (hue_in),
    .r (hue_r),
    .g (hue_g),
    .b (hue_b)
  );

  always_comb begin
    map_r = hue_r;
    map_g = hue_g;
    map_b = hue_b;
    case (mode_q)
      MODE_GREY: begin
        map_r = h_p1;
        map_g = h_p1;
        map_b = h_p1;
      end
      MODE_BLACK: begin
        map_r = '0;
        map_g = '0;
        map_b = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_r     <= '0;
      m_g     <= '0;
      m_b     <= '0;
    end else if (adv) begin
      m_valid <= vld_p1;
      if (vld_p1) begin
        m_r <= map_r;
        m_g <= map_g;
        m_b <= map_b;
      end
    end
  end

endmodule

// File: tb/tb_disp_color_sched.sv
// Scoreboard bench for disp_color_sched on a reduced 8x4 frame.
module tb_disp_color_sched;
  import disp_pkg::*;

  localparam int H = 8;
  localparam int V = 4;
  localparam int PIX = H * V;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] gnt;
  logic       frame_start = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic [2:0] cfg_shift = 3'd0;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic [7:0] s0_data = 8'd0, s1_data = 8'd0;
  logic       s0_ready, s1_ready;
  logic       m_valid, m_ready = 1'b1;
  logic [7:0] m_r, m_g, m_b;
  logic       m_sof, m_eol, frame_done, frame_err;

  disp_color_sched #(.H_ACT(H), .V_ACT(V), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .frame_start(frame_start),
    .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_r(m_r), .m_g(m_g), .m_b(m_b),
    .m_sof(m_sof), .m_eol(m_eol), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, beats = 0, ready_viol = 0;
  int lat_in = 0, lat_out = 0;
  bit lat_arm = 0, bp_en = 0;
  logic [25:0] sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] exp_beat(input int d, input logic [1:0] md,
                                           input logic [2:0] sh, input int idx);
    int h, hh, r, g, b;
    h = d * (1 << sh);
    if (h > 255) h = 255;
    hh = (md == 2'd3) ? 255 - h : h;
    r = hh;
    g = (hh < 128) ? 2 * hh : 511 - 2 * hh;
    b = 255 - hh;
    if (md == 2'd1) begin r = h; g = h; b = h; end
    if (md == 2'd2) begin r = 0; g = 0; b = 0; end
    return {8'(r), 8'(g), 8'(b), idx == 0, (idx % H) == H - 1};
  endfunction

  // Output monitor: random backpressure, event counting, scoreboard pop.
  always @(negedge clk) begin
    m_ready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    #1;
    if (!rst) begin
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
      if ((s0_ready && !gnt[0]) || (s1_ready && !gnt[1])) ready_viol++;
      if (lat_arm && m_valid) begin
        lat_out = cyc;
        lat_arm = 0;
      end
      if (m_valid && m_ready) begin
        beats++;
        if (sbq.size() == 0) check_eq("unexpected_beat", 32'd1, 32'd0);
        else check_eq("beat", {6'd0, m_r, m_g, m_b, m_sof, m_eol}, {6'd0, sbq.pop_front()});
      end
    end
  end

  task automatic run_frame(input logic [1:0] rq, input logic [1:0] eg, input logic [1:0] md,
                           input logic [2:0] sh, input int dconst, input bit gaps,
                           input int err_at, input int abort_at);
    int i, guard, d0, e0, b0, v0, d;
    bit v, fs_done;
    d0 = done_cnt; e0 = err_cnt; b0 = beats; v0 = ready_viol; fs_done = 0;
    @(negedge clk);
    req = rq; cfg_mode = md; cfg_shift = sh; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; cfg_mode = ~md; cfg_shift = ~sh;
    #1 check_eq("gnt", 32'(gnt), 32'(eg));
    i = 0; guard = 0;
    while (i < PIX && guard < 1000) begin
      @(negedge clk);
      guard++;
      frame_start = 1'b0;
      if (err_at >= 0 && i == err_at && !fs_done) begin
        frame_start = 1'b1;
        fs_done = 1;
      end
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = (dconst >= 0) ? dconst : int'($urandom_range(0, 255));
      if (eg[1]) begin
        s1_valid = v; s1_data = 8'(d); s0_valid = 1'b1; s0_data = 8'h5A;
      end else begin
        s0_valid = v; s0_data = 8'(d); s1_valid = 1'b1; s1_data = 8'hA5;
      end
      #1;
      if (v && (eg[1] ? s1_ready : s0_ready)) begin
        if (i == 0) begin lat_in = cyc; lat_arm = 1; end
        sbq.push_back(exp_beat(d, md, sh, i));
        i++;
        if (i == abort_at) begin
          #2 rst = 1'b1;
          #1;
          check_eq("abort_mvalid", 32'(m_valid), 32'd0);
          check_eq("abort_gnt", 32'(gnt), 32'd0);
          check_eq("abort_ready", {30'd0, s0_ready, s1_ready}, 32'd0);
          check_eq("abort_rgb", {8'd0, m_r, m_g, m_b}, 32'd0);
          check_eq("abort_flags", {29'd0, m_sof, m_eol, frame_done}, 32'd0);
          sbq.delete();
          lat_arm = 0;
          s0_valid = 1'b0; s1_valid = 1'b0; frame_start = 1'b0; req = 2'b00;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0; frame_start = 1'b0;
    check_eq("inputs_accepted", 32'(i), 32'(PIX));
    guard = 0;
    while (done_cnt == d0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    #2;
    check_eq("frame_done_count", 32'(done_cnt - d0), 32'd1);
    check_eq("beat_count", 32'(beats - b0), 32'(PIX));
    check_eq("sb_empty", 32'(sbq.size()), 32'd0);
    check_eq("other_ready", 32'(ready_viol - v0), 32'd0);
    check_eq("frame_err_count", 32'(err_cnt - e0), (err_at >= 0) ? 32'd1 : 32'd0);
    check_eq("latency", 32'(lat_out - lat_in), 32'd2);
    check_eq("gnt_idle", 32'(gnt), 32'd0);
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_ready", {30'd0, s0_ready, s1_ready}, 32'd0);
    check_eq("rst_mvalid", 32'(m_valid), 32'd0);
    check_eq("rst_rgb", {8'd0, m_r, m_g, m_b}, 32'd0);
    check_eq("rst_flags", {28'd0, m_sof, m_eol, frame_done, frame_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_frame(2'b11, 2'b01, 2'd0, 3'd0, -1, 1'b0, -1, 0);
    run_frame(2'b11, 2'b10, 2'd0, 3'd0, -1, 1'b0, -1, 0);
    run_frame(2'b11, 2'b01, 2'd0, 3'd0, -1, 1'b0, -1, 0);

    run_frame(2'b01, 2'b01, 2'd0, 3'd0, 'h40, 1'b0, -1, 0);
    run_frame(2'b01, 2'b01, 2'd0, 3'd0, 'hC0, 1'b0, -1, 0);
    run_frame(2'b01, 2'b01, 2'd1, 3'd2, 'h50, 1'b0, -1, 0);
    run_frame(2'b01, 2'b01, 2'd2, 3'd3, -1, 1'b1, -1, 0);
    run_frame(2'b01, 2'b01, 2'd3, 3'd1, -1, 1'b1, -1, 0);

    bp_en = 1;
    run_frame(2'b10, 2'b10, 2'd0, 3'(($urandom_range(0, 2))), -1, 1'b1, -1, 0);
    run_frame(2'b01, 2'b01, 2'd0, 3'd1, -1, 1'b1, 10, 0);
    bp_en = 0;

    e0 = err_cnt;
    @(negedge clk);
    req = 2'b00; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check_eq("idle_noreq_gnt", 32'(gnt), 32'd0);
    check_eq("idle_noreq_err", 32'(err_cnt - e0), 32'd0);

    run_frame(2'b01, 2'b01, 2'd0, 3'd0, -1, 1'b0, -1, 12);
    run_frame(2'b11, 2'b01, 2'd0, 3'd0, -1, 1'b0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_color_sched.md
Name: disp_color_sched

Overview:
- Frame-level scheduler for the shared disparity-to-pseudo-colour datapath on the SGM display path.
- Arbitrates two pixel requesters (0 = SGM disparity stream, 1 = debug/test stream) for whole frames, round-robin.
- Latches per-frame config, applies gain with saturation, then maps the pixel through the hue-to-RGB function.
- Emits a 2-stage valid/ready pixel stream with start-of-frame and end-of-line markers toward the video output.

Parameters:
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.
- CNT_W, 10, width of the x/y counters; must hold H_ACT-1 and V_ACT-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  per-requester frame request, level.
- gnt  out  2  one-hot frame grant; 0 when idle.
- frame_start  in  1  pulse that opens a frame.
- cfg_mode  in  2  mapping mode: 0 pseudo-colour, 1 grey, 2 black, 3 inverted pseudo-colour.
- cfg_shift  in  3  gain, applied as a left shift.
- s0_valid / s0_data / s0_ready  in / in / out  1 / 8 / 1  requester 0 pixel stream.
- s1_valid / s1_data / s1_ready  in / in / out  1 / 8 / 1  requester 1 pixel stream.
- m_valid  out  1  output beat valid.
- m_ready  in  1  output beat accepted.
- m_r, m_g, m_b  out  8 each  output colour.
- m_sof  out  1  first beat of the frame.
- m_eol  out  1  last beat of a line.
- frame_done  out  1  one-cycle pulse after the last beat.
- frame_err  out  1  one-cycle pulse when frame_start arrives while not IDLE.

Behaviour:
- Reset (async, immediate): state IDLE; gnt=0; s0_ready=s1_ready=0; m_valid=0; m_r/g/b=0; m_sof=m_eol=0; frame_done=frame_err=0; counters=0; last_gnt=1, so requester 0 wins first.
- Reset during RUN aborts the frame; in-flight pixels are discarded.
- IDLE -> RUN on frame_start with req!=0:
  - Grant one-hot by round-robin: the requester not equal to last_gnt wins if requesting, otherwise the other.
  - Latch cfg_mode and cfg_shift into frame registers; they are stable for the whole frame.
- frame_start with req==0 in IDLE: ignored, no error.
- frame_start in RUN or DRAIN: ignored; frame_err pulses 1 cycle.
- RUN:
  - Only the granted requester's s*_ready can be 1. The other's ready is 0.
  - Pipeline advance: adv = m_ready | ~m_valid. Stage-1 advance: adv1 = adv | ~v1.
  - Granted s_ready = adv1 while the input beat count is < H_ACT*V_ACT; 0 afterwards.
  - Stage 1 (register): h = data << shift, saturated to 255 if any shifted-out bit is 1 (e.g. 0x50<<2 = 0xFF, 0x30<<2 = 0xC0).
  - Stage 2 (register): colour map per frame mode:
    - pseudo: R=h; G = h[7] ? ~{h[6:0],0} : {h[6:0],0}; B=~h.
    - grey: R=G=B=h.
    - black: R=G=B=0.
    - invert: pseudo applied to ~h.
  - Latency: 2 clk from input handshake to m_valid with no backpressure. Full throughput of 1 pixel/clk.
  - m_ready low: output and both stages hold, including data and flags. No beat is lost or duplicated.
- Output counters x,y advance on each m_valid&m_ready handshake.
  - m_sof = (x==0 && y==0). m_eol = (x==H_ACT-1).
  - x wraps to 0 at H_ACT-1 and y increments.
- After all H_ACT*V_ACT inputs are accepted: RUN -> DRAIN.
- DRAIN -> IDLE when the final beat (x=H_ACT-1, y=V_ACT-1) handshakes:
  - frame_done pulses; gnt -> 0; last_gnt updated; counters cleared.
- Simultaneous final handshake and frame_start: the frame_start is ignored (frame_err). A new frame requires frame_start while IDLE.

Decomposition:
- Package disp_pkg holds:
  - Mode encoding constants MODE_PSEUDO=0, MODE_GREY=1, MODE_BLACK=2, MODE_INV=3.
  - State enum IDLE/RUN/DRAIN.
  - A pixel count function returning H_ACT*V_ACT.
- Sub-module hue_to_rgb: purely combinational 8-bit h -> R,G,B pseudo-colour mapping. It is instantiated in stage 2; mode muxing stays in the parent.

Test Plan:
- Grant and latency: req=2'b01, frame_start, mode 0, shift 0, s0_data=0x40, m_ready=1 -> gnt=01; 2 clk after the input handshake m_r=0x40, m_g=0x80, m_b=0xBF with m_sof=1.
- Mapping and saturation:
  - data 0xC0, mode 0: R=0xC0, G=0x7F, B=0x3F.
  - data 0x50, shift 2: h=0xFF, grey mode -> R=G=B=0xFF.
  - mode 2 -> all 0.
- Backpressure: random m_ready with 30% low duty over a reduced frame (H_ACT=8, V_ACT=4) -> 32 beats in order, data equal to the scoreboard, m_eol on every 8th beat, exactly one frame_done.
- Round-robin: req=2'b11 over three frames -> gnt sequence 01, 10, 01; the non-granted s*_ready stays 0 throughout.
- Errors and reset: frame_start mid-frame -> frame_err pulse and frame unaffected; async rst mid-frame -> all outputs 0 immediately, next frame starts clean with m_sof on its first beat.
